mem_arbiter: RTL

Sequencer/arbiter that shares the single data-memory access port between the instruction-fetch stage and the load/store stage of the three-stage pipeline. It accepts one request per access slot, drives the memory address/data/write-enable for a fixed latency, returns read data with a valid pulse, and raises a fetch stall while fetch is blocked. Load/store has priority; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arb_starve_ctr.sv | 27 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and default widths for the memory arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory port bundle of the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  // Requesters and the memory model
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_wdata, mem_we, stall
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_wdata, mem_we, stall
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating count of fetch arbitration losses
module mem_arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);
  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  assign o_at_max = (r_cnt == CW'(MAX));

  // Clear wins over increment; hold once the limit is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_at_max) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and load/store; MEM_ARBITER_STATS_EN adds grant statistics
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]    stat_if_gnts,
  output logic [31:0]    stat_ls_gnts,
  output logic [31:0]    stat_conflicts
`endif
);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_rdata;
  logic [LAT_W-1:0]  r_lat;

  logic w_arb;
  logic w_at_max;
  logic w_pick_if;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_last;

  // Grants are only issued from IDLE/RESP, and never while reset is held
  assign w_arb     = rst_n && (r_state != BUSY);
  assign w_pick_if = bus.if_req && (!bus.ls_req || w_at_max);
  assign w_if_gnt  = w_arb && w_pick_if;
  assign w_ls_gnt  = w_arb && bus.ls_req && !w_pick_if;
  assign w_last    = (r_state == BUSY) && (r_lat == LAT_W'(MEM_LAT - 1));

  mem_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_ls_gnt && bus.if_req),
    .i_clr    (w_if_gnt || !bus.if_req),
    .o_at_max (w_at_max)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: a grant starts a BUSY phase; RESP falls back to IDLE when nobody asks
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_if_gnt || w_ls_gnt) w_state_nxt = BUSY;
      BUSY:    if (w_last) w_state_nxt = RESP;
      RESP:    w_state_nxt = (w_if_gnt || w_ls_gnt) ? BUSY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the winner's access and sample read data at the end of BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_IF;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_lat   <= '0;
    end else begin
      if (w_if_gnt) begin
        r_owner <= OWN_IF;
        r_addr  <= bus.if_addr;
        r_wdata <= '0;
        r_we    <= 1'b0;
        r_lat   <= '0;
      end else if (w_ls_gnt) begin
        r_owner <= OWN_LS;
        r_addr  <= bus.ls_addr;
        r_wdata <= bus.ls_wdata;
        r_we    <= bus.ls_we;
        r_lat   <= '0;
      end else if (r_state == BUSY && !w_last) begin
        r_lat   <= r_lat + LAT_W'(1);
      end
      if (w_last) r_rdata <= r_we ? '0 : bus.mem_rdata;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.if_rvalid = (r_state == RESP) && (r_owner == OWN_IF);
  assign bus.ls_rvalid = (r_state == RESP) && (r_owner == OWN_LS);
  assign bus.if_rdata  = (r_owner == OWN_IF) ? r_rdata : '0;
  assign bus.ls_rdata  = (r_owner == OWN_LS) ? r_rdata : '0;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_we    = w_last && r_we;
  assign bus.stall     = rst_n && bus.if_req && !w_if_gnt;

`ifdef MEM_ARBITER_STATS_EN
  // Saturating grant and contention counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_gnts   <= '0;
      stat_ls_gnts   <= '0;
      stat_conflicts <= '0;
    end else begin
      if (w_if_gnt && stat_if_gnts != '1) stat_if_gnts <= stat_if_gnts + 32'd1;
      if (w_ls_gnt && stat_ls_gnts != '1) stat_ls_gnts <= stat_ls_gnts + 32'd1;
      if (w_arb && bus.if_req && bus.ls_req && stat_conflicts != '1)
        stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif
endmodule
